// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter that lets NumReq requesters share one NoC PE injection port.
// A winner owns the port for a whole PktFlits-flit packet; its VC select is latched at grant time.
module noc_inject_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 8,
    parameter int unsigned ViChAddr  = 1,
    parameter int unsigned PktFlits  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NumReq-1:0]             ReqValid,
    input  logic [NumReq*DataWidth-1:0]   ReqData,
    input  logic [NumReq*ViChAddr-1:0]    ReqSel,
    output logic [NumReq-1:0]             ReqReady,
    output logic [DataWidth-1:0]          InpData,
    output logic                          InpEn,
    input  logic                          InpReady,
    output logic [ViChAddr-1:0]           InpSel,
    output logic [NumReq-1:0]             Grant,
    output logic                          PktDone
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [PtrW-1:0]     gidx_q, gidx_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic [ViChAddr-1:0] sel_q, sel_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                done_q, done_d;

    logic                win_found;
    logic [PtrW-1:0]     win_idx;
    logic [ViChAddr-1:0] win_sel;
    logic [DataWidth-1:0] own_data;
    logic                own_valid;
    logic                xfer;
    logic                last_flit;

    // Search upward from ptr_q, wrapping at NumReq; first valid requester wins.
    always_comb begin
        logic [PtrW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = PtrW'((32'(ptr_q) + k) % NumReq);
            if (!win_found && ReqValid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_sel   = '0;
        own_data  = '0;
        own_valid = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (win_idx == PtrW'(k)) begin
                win_sel = ReqSel[k*ViChAddr +: ViChAddr];
            end
            if (gidx_q == PtrW'(k)) begin
                own_data  = ReqData[k*DataWidth +: DataWidth];
                own_valid = ReqValid[k];
            end
        end
    end

    assign xfer      = (state_q == BUSY) && own_valid && InpReady;
    assign last_flit = (cnt_q == CntW'(PktFlits - 1));

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (win_found) begin
                    state_d          = BUSY;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                    sel_d            = win_sel;
                    cnt_d            = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (last_flit) begin
                        state_d = IDLE;
                        grant_d = '0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        ptr_d   = (gidx_q == PtrW'(NumReq - 1)) ? '0 : gidx_q + PtrW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ReqReady = '0;
        InpData  = '0;
        InpEn    = 1'b0;
        if (state_q == BUSY) begin
            InpEn            = own_valid;
            InpData          = own_data;
            ReqReady[gidx_q] = InpReady;
        end
        InpSel  = sel_q;
        Grant   = grant_q;
        PktDone = done_q;
    end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: vector tables plus hand-written multi-cycle sequences.
module tb_noc_inject_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_sel;
    logic        inp_ready;

    logic [3:0]  a_rdy, b_rdy;
    logic [7:0]  a_data, b_data;
    logic        a_en, b_en;
    logic [0:0]  a_sel, b_sel;
    logic [3:0]  a_grant, b_grant;
    logic        a_done, b_done;

    int tests = 0;
    int fails = 0;

    noc_inject_arbiter #(.NumReq(4), .DataWidth(8), .ViChAddr(1), .PktFlits(4)) dut_a (
        .clock(clk), .reset(rst), .ReqValid(req_valid), .ReqData(req_data), .ReqSel(req_sel),
        .ReqReady(a_rdy), .InpData(a_data), .InpEn(a_en), .InpReady(inp_ready),
        .InpSel(a_sel), .Grant(a_grant), .PktDone(a_done)
    );

    noc_inject_arbiter #(.NumReq(4), .DataWidth(8), .ViChAddr(1), .PktFlits(1)) dut_b (
        .clock(clk), .reset(rst), .ReqValid(req_valid), .ReqData(req_data), .ReqSel(req_sel),
        .ReqReady(b_rdy), .InpData(b_data), .InpEn(b_en), .InpReady(inp_ready),
        .InpSel(b_sel), .Grant(b_grant), .PktDone(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       ready;
        logic [3:0] grant;
        logic       en;
        logic [3:0] rdy;
        logic       done;
        logic       chk_data;
        logic [7:0] data;
        bit         dut_b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rd,
                                input logic [3:0] g, input logic e, input logic [3:0] rr,
                                input logic d, input logic cd, input logic [7:0] dt, input bit b);
        vec_t x;
        x.rst = r; x.valid = v; x.ready = rd; x.grant = g; x.en = e; x.rdy = rr;
        x.done = d; x.chk_data = cd; x.data = dt; x.dut_b = b;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        inp_ready = 1'b0;
        req_sel   = '0;
        req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_vecs(input string tag);
        vec_t v;
        logic [3:0] g, rr;
        logic e, d;
        logic [7:0] dt;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst; req_valid = v.valid; inp_ready = v.ready;
            @(negedge clk);
            if (v.dut_b) begin
                g = b_grant; e = b_en; rr = b_rdy; d = b_done; dt = b_data;
            end else begin
                g = a_grant; e = a_en; rr = a_rdy; d = a_done; dt = a_data;
            end
            chk($sformatf("%s[%0d] Grant", tag, i), 32'(g), 32'(v.grant));
            chk($sformatf("%s[%0d] InpEn", tag, i), 32'(e), 32'(v.en));
            chk($sformatf("%s[%0d] ReqReady", tag, i), 32'(rr), 32'(v.rdy));
            chk($sformatf("%s[%0d] PktDone", tag, i), 32'(d), 32'(v.done));
            if (v.chk_data) chk($sformatf("%s[%0d] InpData", tag, i), 32'(dt), 32'(v.data));
            @(posedge clk); #1;
        end
        vecs.delete();
    endtask

    initial begin
        int  k, busy;
        bit  finished, xfer_now;
        logic [7:0] got[$];
        int  ph, p;
        logic [3:0] g;

        // All four requesting: 0001,0010,0100,1000,0001 with one idle cycle per packet
        do_reset();
        vecs.push_back(mk(1, 4'hF, 1, 4'h0, 0, 4'h0, 0, 0, 8'h00, 0));
        for (int c = 0; c < 25; c++) begin
            ph = c % 5;
            p  = (c / 5) % 4;
            g  = 4'(1 << p);
            if (ph == 0) vecs.push_back(mk(0, 4'hF, 1, 4'h0, 0, 4'h0, (c > 0), 0, 8'h00, 0));
            else         vecs.push_back(mk(0, 4'hF, 1, g, 1, g, 0, 1, 8'(8'h10 * (p + 1)), 0));
        end
        run_vecs("rr4");

        // Owner stalls mid-packet while requester 3 waits
        do_reset();
        vecs.push_back(mk(0, 4'b1010, 1, 4'h0, 0, 4'h0, 0, 0, 8'h00, 0));
        for (int c = 1; c <= 2; c++) vecs.push_back(mk(0, 4'b1010, 1, 4'b0010, 1, 4'b0010, 0, 1, 8'h20, 0));
        for (int c = 3; c <= 7; c++) vecs.push_back(mk(0, 4'b1000, 1, 4'b0010, 0, 4'b0010, 0, 1, 8'h20, 0));
        for (int c = 8; c <= 9; c++) vecs.push_back(mk(0, 4'b1010, 1, 4'b0010, 1, 4'b0010, 0, 1, 8'h20, 0));
        vecs.push_back(mk(0, 4'b1010, 1, 4'h0, 0, 4'h0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1010, 1, 4'b1000, 1, 4'b1000, 0, 1, 8'h40, 0));
        run_vecs("stall");

        // Reset mid-packet after pointer has advanced past requester 0
        do_reset();
        vecs.push_back(mk(0, 4'b0001, 1, 4'h0, 0, 4'h0, 0, 0, 8'h00, 0));
        for (int c = 1; c <= 4; c++) vecs.push_back(mk(0, 4'b0001, 1, 4'b0001, 1, 4'b0001, 0, 1, 8'h10, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 4'h0, 0, 4'h0, 1, 0, 8'h00, 0));
        for (int c = 6; c <= 8; c++) vecs.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 4'b0010, 0, 1, 8'h20, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 4'b0010, 0, 4'h0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0011, 1, 4'h0, 0, 4'h0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0011, 1, 4'b0001, 1, 4'b0001, 0, 1, 8'h10, 0));
        run_vecs("midrst");

        // Single-flit packets alternate between requesters 0 and 3
        do_reset();
        vecs.push_back(mk(0, 4'b1001, 1, 4'h0, 0, 4'h0, 0, 0, 8'h00, 1));
        for (int c = 0; c < 3; c++) begin
            g = (c % 2 == 0) ? 4'b0001 : 4'b1000;
            vecs.push_back(mk(0, 4'b1001, 1, g, 1, g, 0, 1, (c % 2 == 0) ? 8'h10 : 8'h40, 1));
            vecs.push_back(mk(0, 4'b1001, 1, 4'h0, 0, 4'h0, 1, 0, 8'h00, 1));
        end
        run_vecs("flit1");

        // Requester 2 alone, InpReady toggling: A0..A3 in order over 8 owned cycles
        do_reset();
        req_data[23:16] = 8'hA0;
        req_sel   = 4'b0100;
        req_valid = 4'b0100;
        inp_ready = 1'b1;
        @(negedge clk);
        chk("tog idle Grant", 32'(a_grant), 32'h0);
        @(posedge clk); #1;
        k = 0; busy = 0; finished = 0;
        for (int c = 1; c <= 20 && !finished; c++) begin
            inp_ready = (c % 2 == 0);
            xfer_now  = 0;
            @(negedge clk);
            if (a_grant != 4'h0) begin
                busy++;
                chk($sformatf("tog c%0d Grant", c), 32'(a_grant), 32'h4);
                chk($sformatf("tog c%0d InpSel", c), 32'(a_sel), 32'h1);
                chk($sformatf("tog c%0d InpEn", c), 32'(a_en), 32'h1);
                if (a_en && inp_ready) begin
                    got.push_back(a_data);
                    xfer_now = 1;
                end
            end else if (busy > 0) begin
                finished = 1;
                chk("tog PktDone", 32'(a_done), 32'h1);
            end
            @(posedge clk); #1;
            if (xfer_now) k++;
            req_data[23:16] = 8'(8'hA0 + k);
        end
        if (!finished) chk("tog timeout", 32'h0, 32'h1);
        chk("tog busy cycles", 32'(busy), 32'd8);
        chk("tog flit count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk($sformatf("tog flit%0d", i), 32'(got[i]), 32'(8'hA0 + i));
        req_valid = '0;

        // Owner's ReqSel flips mid-packet; InpSel holds until the next grant
        do_reset();
        req_valid = 4'b0001;
        inp_ready = 1'b1;
        @(negedge clk);
        chk("vc idle Grant", 32'(a_grant), 32'h0);
        @(posedge clk); #1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) req_sel = 4'b0001;
            @(negedge clk);
            chk($sformatf("vc c%0d Grant", c), 32'(a_grant), 32'h1);
            chk($sformatf("vc c%0d InpSel", c), 32'(a_sel), 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("vc end Grant", 32'(a_grant), 32'h0);
        chk("vc end PktDone", 32'(a_done), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("vc next Grant", 32'(a_grant), 32'h1);
        chk("vc next InpSel", 32'(a_sel), 32'h1);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, number of requesters sharing one PE injection port.
REQ-002 The block SHALL have parameter DataWidth, default 8, flit width.
REQ-003 The block SHALL have parameter ViChAddr, default 1, virtual-channel select width.
REQ-004 The block SHALL have parameter PktFlits, default 4, flits per packet, legal range 1..16.
REQ-005 The block SHALL have port clock, input, 1, sole clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port ReqValid, input, NumReq, per-requester flit valid.
REQ-008 The block SHALL have port ReqData, input, NumReq*DataWidth, per-requester flit; requester i occupies bits [i*DataWidth +: DataWidth].
REQ-009 The block SHALL have port ReqSel, input, NumReq*ViChAddr, per-requester VC select; requester i occupies bits [i*ViChAddr +: ViChAddr].
REQ-010 The block SHALL have port ReqReady, output, NumReq, per-requester flit accept.
REQ-011 The block SHALL have port InpData, output, DataWidth, flit to NoC PE input.
REQ-012 The block SHALL have port InpEn, output, 1, flit valid to NoC.
REQ-013 The block SHALL have port InpReady, input, 1, NoC accepts flit.
REQ-014 The block SHALL have port InpSel, output, ViChAddr, VC select to NoC.
REQ-015 The block SHALL have port Grant, output, NumReq, one-hot current owner; all zero when idle.
REQ-016 The block SHALL have port PktDone, output, 1, one-cycle pulse after the last flit of a packet transfers.

Function
REQ-017 A flit transfer SHALL occur in a cycle where InpEn=1 and InpReady=1.
REQ-018 The FSM SHALL have states IDLE and BUSY.
REQ-019 In IDLE with any ReqValid set, the block SHALL select a winner round-robin, searching upward from index Ptr with wrap at NumReq, and enter BUSY next cycle.
REQ-020 On the IDLE->BUSY edge, the block SHALL register Grant to the winner one-hot, latch InpSel from the winner's ReqSel, and clear the flit counter.
REQ-021 In IDLE with no ReqValid set, the block SHALL stay in IDLE with Grant=0.
REQ-022 In BUSY, InpEn SHALL equal ReqValid[g] and InpData SHALL equal the granted requester's ReqData, combinationally.
REQ-023 In BUSY, ReqReady[g] SHALL equal InpReady; all other ReqReady bits and all ReqReady in IDLE SHALL be 0.
REQ-024 InpSel SHALL hold constant for the whole packet; ReqSel changes during BUSY SHALL be ignored.
REQ-025 The flit counter SHALL increment on each transfer in BUSY.
REQ-026 On the transfer of flit PktFlits-1, the FSM SHALL return to IDLE, set Ptr to (g+1) mod NumReq, clear Grant, and pulse PktDone in the following cycle.
REQ-027 Between consecutive packets, exactly one IDLE cycle with InpEn=0 SHALL occur.
REQ-028 If the granted requester deasserts ReqValid mid-packet, grant SHALL be held with InpEn=0, with no timeout and no preemption.
REQ-029 If InpReady stays low, the block SHALL hold state, counter and InpData without loss or duplication.
REQ-030 Requests raised during BUSY SHALL NOT affect the current packet and SHALL be arbitrated at the next IDLE.
REQ-031 When PktFlits=1, every transfer SHALL end the packet.

Reset
REQ-032 When reset=1 at a clock edge, the block SHALL set state IDLE, Ptr=0, counter=0, Grant=0, InpSel=0 and PktDone=0; InpEn and ReqReady SHALL then be 0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no further transfers and no PktDone pulse.
REQ-034 After reset releases, the first arbitration SHALL favour requester 0.

Verification
REQ-035 The bench SHALL cover: reset, then ReqValid=4'b1111 held with InpReady=1 -> Grant sequence 0001,0010,0100,1000,0001; each packet 4 flits; one idle cycle between packets; PktDone pulses 4 times per 20 cycles.
REQ-036 The bench SHALL cover: requester 2 only, data 8'hA0..A3, ReqSel=1, InpReady toggling 1,0,1,0 -> NoC sees A0,A1,A2,A3 in order, InpSel=1 throughout, packet completes in 8 BUSY cycles.
REQ-037 The bench SHALL cover: requester 1 drops ReqValid after flit 1 for 5 cycles while requester 3 requests -> Grant stays 0010, InpEn=0 for those cycles, requester 3 is granted only after requester 1's flit 3.
REQ-038 The bench SHALL cover: ReqSel of the owner changes 0->1 mid-packet -> InpSel stays 0 until the packet ends.
REQ-039 The bench SHALL cover: reset pulsed after flit 2 of a packet from requester 1 -> next cycle InpEn=0, Grant=0, no PktDone; with ReqValid=4'b0011 the next grant is 0001.
REQ-040 The bench SHALL cover: PktFlits=1 with requesters 0 and 3 valid -> grants alternate 0001,1000, each with one flit and one idle cycle.
